fetch_sequencer: RTL
====================

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, width of the data bus, opcode and each operand byte.
REQ-002 Parameter: ADDR_WIDTH, default 2*DATA_WIDTH; informational only, no ports use it.
REQ-003 Port: clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-low reset.
REQ-005 Port: start  input  1  request one instruction fetch; sampled in IDLE only.
REQ-006 Port: mem_ready  input  1  memory has valid read data on data_in this cycle.
REQ-007 Port: data_in  input  DATA_WIDTH  byte read from memory at the current program-counter address.
REQ-008 Port: instr_ack  input  1  consumer accepts the held instruction.
REQ-009 Port: pc_oe_a  output  1  drives the program counter's address output enable; high during every read state.
REQ-010 Port: mem_rd  output  1  memory read strobe; high during every read state.
REQ-011 Port: pc_cnt_en  output  1  one-cycle program counter increment pulse per accepted byte.
REQ-012 Port: opcode  output  DATA_WIDTH  captured opcode byte.
REQ-013 Port: operand  output  2*DATA_WIDTH  captured operands; byte 1 in the low half, byte 2 in the high half.
REQ-014 Port: instr_valid  output  1  complete instruction held in opcode/operand.
REQ-015 Port: busy  output  1  high in any state other than IDLE.

Function
REQ-016 The FSM SHALL have states IDLE, RD_OP, RD_B1, RD_B2 and HOLD.
- Read states: RD_OP, RD_B1, RD_B2.
REQ-017 In IDLE, start=1 SHALL move the FSM to RD_OP on the next edge; otherwise it stays in IDLE.
REQ-018 In a read state, a byte SHALL be accepted on an edge where mem_ready=1.
- pc_cnt_en is high combinationally in that same cycle.
- The byte is registered at that edge.
- If mem_ready=0, the FSM stays in its state with no pc_cnt_en.
REQ-019 Instruction length SHALL come from opcode[DATA_WIDTH-1:DATA_WIDTH-2]:
- 00 or 11: 1 byte.
- 01: 2 bytes.
- 10: 3 bytes.
REQ-020 From RD_OP, acceptance SHALL go to HOLD (1 byte) or RD_B1 (2 or 3 bytes).
REQ-021 From RD_B1, acceptance SHALL go to HOLD (2 bytes) or RD_B2 (3 bytes).
REQ-022 From RD_B2, acceptance SHALL go to HOLD.
REQ-023 On entry to RD_OP, operand SHALL clear to zero, so unused operand bytes read as zero.
REQ-024 instr_valid SHALL be high exactly in HOLD.
- opcode/operand hold stable in HOLD.
REQ-025 In HOLD, instr_ack=1 SHALL move the FSM to IDLE.
- instr_ack=1 with start=1 in the same cycle moves it directly to RD_OP (back-to-back fetch).
REQ-026 instr_ack outside HOLD and start outside IDLE SHALL be ignored.
REQ-027 Minimum latency SHALL be 1+N cycles from start to instr_valid, for N bytes with mem_ready held at 1.

Reset
REQ-028 reset=0 SHALL immediately force:
- state=IDLE;
- opcode=0 and operand=0;
- instr_valid, busy, mem_rd, pc_oe_a and pc_cnt_en all 0.
REQ-029 Reset asserted mid-fetch SHALL abandon the fetch with no further pc_cnt_en pulse.
REQ-030 After release, the block SHALL wait in IDLE for start.

Configuration
REQ-031 With macro FETCH_WAIT_STATE_EN defined, mem_ready SHALL gate byte acceptance as in REQ-018.
REQ-032 Without FETCH_WAIT_STATE_EN, mem_ready SHALL be ignored and treated as constant 1.
- Every read state lasts exactly one cycle.

Verification
REQ-033 The bench SHALL cover at least these scenarios:
- 1-byte fetch: start, data_in=8'h05 -> instr_valid on cycle 2, opcode=8'h05, operand=16'h0000, one pc_cnt_en pulse.
- 3-byte fetch: bytes 8'h8A, 8'h34, 8'h12 -> instr_valid on cycle 4, operand=16'h1234, three pc_cnt_en pulses.
- Wait states (macro on): 2-byte opcode 8'h41, mem_ready low for 2 cycles before each byte -> instr_valid on cycle 7, no pc_cnt_en while mem_ready=0.
- Back-to-back: instr_ack=1 and start=1 together in HOLD -> next cycle in RD_OP, operand cleared.
- Reset mid-fetch: reset=0 in RD_B1 -> busy=0 and opcode=0 immediately; no pc_cnt_en until the next start.
- Macro off: mem_ready tied 0, 2-byte fetch -> completes in 3 cycles.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction fetch FSM: reads a 1-3 byte instruction and holds it for a consumer.
// Define FETCH_WAIT_STATE_EN to let mem_ready stall the read states.
module fetch_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2 * DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    mem_ready,
  input  logic [DATA_WIDTH-1:0]   data_in,
  input  logic                    instr_ack,
  output logic                    pc_oe_a,
  output logic                    mem_rd,
  output logic                    pc_cnt_en,
  output logic [DATA_WIDTH-1:0]   opcode,
  output logic [2*DATA_WIDTH-1:0] operand,
  output logic                    instr_valid,
  output logic                    busy
);

  localparam int DW = DATA_WIDTH;
  localparam int unused_aw = ADDR_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    RD_OP,
    RD_B1,
    RD_B2,
    HOLD
  } state_t;

  state_t     state;
  state_t     next;
  logic       rdy;
  logic       rd_state;
  logic       accept;
  logic       enter_op;
  logic [1:0] len;

`ifdef FETCH_WAIT_STATE_EN
  assign rdy = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign rdy = 1'b1;
`endif

  // The length field comes off the bus while the opcode is being read.
  assign len = (state == RD_OP) ? data_in[DW-1:DW-2]
                                : opcode[DW-1:DW-2];

  always_comb begin
    next     = state;
    rd_state = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) next = RD_OP;
      end
      RD_OP: begin
        rd_state = 1'b1;
        if (rdy) begin
          if (len == 2'b01 || len == 2'b10) next = RD_B1;
          else next = HOLD;
        end
      end
      RD_B1: begin
        rd_state = 1'b1;
        if (rdy) next = (len == 2'b10) ? RD_B2 : HOLD;
      end
      RD_B2: begin
        rd_state = 1'b1;
        if (rdy) next = HOLD;
      end
      HOLD: begin
        if (instr_ack) next = start ? RD_OP : IDLE;
      end
      default: next = IDLE;
    endcase
  end

  assign accept      = rd_state & rdy;
  assign enter_op    = (next == RD_OP) && (state != RD_OP);
  assign pc_cnt_en   = accept;
  assign mem_rd      = rd_state;
  assign pc_oe_a     = rd_state;
  assign instr_valid = (state == HOLD);
  assign busy        = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      opcode  <= '0;
      operand <= '0;
    end else begin
      state <= next;
      if (enter_op) operand <= '0;
      if (accept) begin
        unique case (1'b1)
          (state == RD_OP): opcode <= data_in;
          (state == RD_B1): operand[DW-1:0] <= data_in;
          (state == RD_B2): operand[2*DW-1:DW] <= data_in;
          default: ;
        endcase
      end
    end
  end

endmodule
